muldiv_unit: RTL

//  Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_arith.sv | 82 ++++++++
 rtl/muldiv_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encoding and the latency counter width helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Width needed to hold the larger of the two latencies.
  function automatic int lat_cnt_w(input int mul_lat, input int div_lat);
    int m;
    m = (mul_lat > div_lat) ? mul_lat : div_lat;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/muldiv_arith.sv
// Combinational arithmetic core: full-width product, truncating divide with
// defined divide-by-zero and MIN/-1 results, optional multiply-accumulate.
// Optional feature macro: MULDIV_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
module muldiv_arith
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] acc_hi,
  input  logic [DATA_W-1:0] acc_lo,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  localparam int W2 = 2 * DATA_W;
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  // op[0] set selects the unsigned variant of every op class.
  logic              is_signed;
  logic              a_neg, b_neg;
  logic [W2-1:0]     a_ext, b_ext, prod, acc;
  logic [DATA_W-1:0] abs_a, abs_b, uq, ur, quo, rem;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[DATA_W-1];
  assign b_neg     = is_signed & b[DATA_W-1];

  // Extending to 2*DATA_W and keeping the low half of the product gives the
  // exact signed or unsigned product without needing signed types.
  assign a_ext = is_signed ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
  assign b_ext = is_signed ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
  assign prod  = a_ext * b_ext;
  assign acc   = {acc_hi, acc_lo};

  // A single unsigned divider serves both DIV and DIVU via magnitudes.
  assign abs_a = a_neg ? (~a + 1'b1) : a;
  assign abs_b = b_neg ? (~b + 1'b1) : b;
  assign uq    = (abs_b == '0) ? '0 : (abs_a / abs_b);
  assign ur    = (abs_b == '0) ? '0 : (abs_a % abs_b);
  assign quo   = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
  assign rem   = a_neg ? (~ur + 1'b1) : ur;

  // Select the HI/LO result for the latched op class.
  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
    case (op)
      OP_MULT, OP_MULTU: begin
        res_hi = prod[W2-1:DATA_W];
        res_lo = prod[DATA_W-1:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          res_hi = a;
          res_lo = '1;
        end else if (is_signed && (a == MIN_VAL) && (b == '1)) begin
          res_hi = '0;
          res_lo = MIN_VAL;
        end else begin
          res_hi = rem;
          res_lo = quo;
        end
      end
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU: begin
        {res_hi, res_lo} = acc + prod;
      end
      OP_MSUB, OP_MSUBU: begin
        {res_hi, res_lo} = acc - prod;
      end
`endif
      default: begin
        res_hi = acc_hi;
        res_lo = acc_lo;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are latched at launch; the result is released into HI/LO with a
// one-cycle done pulse on the edge where busy falls.
// Optional feature macro: MULDIV_MADD_EN (multiply-accumulate ops 1xx).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = lat_cnt_w(MUL_LAT, DIV_LAT);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] res_hi, res_lo;
  logic              op_valid, op_is_div;

`ifdef MULDIV_MADD_EN
  assign op_valid = 1'b1;
`else
  assign op_valid = ~op[2];
`endif
  assign op_is_div = (op[2:1] == 2'b01);

  muldiv_arith #(.DATA_W(DATA_W)) u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .acc_hi (acc_hi_q),
    .acc_lo (acc_lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Next-state logic: MTHI/MTLO and launch in IDLE, countdown and release in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && op_valid) begin
          state_d  = ST_RUN;
          cnt_d    = op_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
          op_d     = op;
          a_d      = src_a;
          b_d      = src_b;
          // Accumulator sees a same-cycle MTHI/MTLO write.
          acc_hi_d = hi_d;
          acc_lo_d = lo_d;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset clears everything and discards any pending op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
